score_keeper: RTL and testbench



---
 rtl/pong_pkg.sv | 28 ++
 rtl/edge_detect.sv | 38 +++
 rtl/score_keeper.sv | 216 +++++++++++++++++++++
 tb/tb_score_keeper.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks: FSM state encoding,
// score width and the largest score the LED score bar can show.
package pong_pkg;

  localparam int SCORE_W           = 4;
  localparam int MAX_DISPLAY_SCORE = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    SERVE = 3'd2,
    PLAY  = 3'd3,
    OVER  = 3'd4
  } state_e;

  // Add one to a score but never go past the limit, so a score cannot wrap.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] score,
                                                input logic [SCORE_W-1:0] limit);
    logic [SCORE_W-1:0] result;
    if (score < limit) begin
      result = score + SCORE_W'(1);
    end else begin
      result = score;
    end
    return result;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// 1-bit rising-edge pulse generator with a registered output.
// Only built when POINT_EDGE_DETECT_EN is defined, since it is the only
// user of this block; a level held high produces a single one-cycle pulse,
// delivered one clock after the rising edge is sampled.
`ifdef POINT_EDGE_DETECT_EN
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;
  logic level_d;
  logic pulse_q;
  logic pulse_d;

  // Next-state: remember the level and flag a low-to-high transition.
  always_comb begin
    level_d = level_i;
    pulse_d = level_i & ~level_q;
  end

  // Edge registers, cleared by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule
`endif

// File: rtl/score_keeper.sv
// Match-scoring controller for the pong game. Writes the per-player score
// values for the LED score bar, times serves through a serve_req/serve_ack
// handshake with the ball module, and detects the match winner.
// Optional macro POINT_EDGE_DETECT_EN: rising-edge detect new_game,
// point_p1 and point_p2 (one extra cycle of latency) so that level-held
// switches or keys count once.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 10,
  parameter int SERVE_DELAY = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_game,
  input  logic               point_p1,
  input  logic               point_p2,
  input  logic               serve_ack,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               serve_req,
  output logic               in_play,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  // Reject configurations the score bar or delay counter cannot represent.
  if ((WIN_SCORE < 1) || (WIN_SCORE > MAX_DISPLAY_SCORE)) begin : g_bad_win_score
    $error("score_keeper: WIN_SCORE must be in 1..%0d", MAX_DISPLAY_SCORE);
  end
  if (SERVE_DELAY < 1) begin : g_bad_serve_delay
    $error("score_keeper: SERVE_DELAY must be at least 1");
  end
  if ((SERVE_DELAY >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("score_keeper: CNT_W too narrow for SERVE_DELAY");
  end

  // Event strobes seen by the FSM, either raw pulses or detected edges.
  logic new_game_evt;
  logic p1_evt;
  logic p2_evt;

`ifdef POINT_EDGE_DETECT_EN
  edge_detect u_new_game_edge (
    .clock   (clock),
    .reset   (reset),
    .level_i (new_game),
    .pulse_o (new_game_evt)
  );

  edge_detect u_point_p1_edge (
    .clock   (clock),
    .reset   (reset),
    .level_i (point_p1),
    .pulse_o (p1_evt)
  );

  edge_detect u_point_p2_edge (
    .clock   (clock),
    .reset   (reset),
    .level_i (point_p2),
    .pulse_o (p2_evt)
  );
`else
  assign new_game_evt = new_game;
  assign p1_evt       = point_p1;
  assign p2_evt       = point_p2;
`endif

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [SCORE_W-1:0] score_p1_q,  score_p1_d;
  logic [SCORE_W-1:0] score_p2_q,  score_p2_d;
  logic               serve_req_q, serve_req_d;
  logic               in_play_q,   in_play_d;
  logic               game_over_q, game_over_d;
  logic               winner_q,    winner_d;

  logic [SCORE_W-1:0] p1_inc;
  logic [SCORE_W-1:0] p2_inc;

  // Next state and next registered outputs; new_game outranks every other
  // event, and point pulses only matter while a rally is live.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    serve_req_d = serve_req_q;
    in_play_d   = in_play_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    p1_inc      = sat_inc(score_p1_q, WIN_VAL);
    p2_inc      = sat_inc(score_p2_q, WIN_VAL);

    if (new_game_evt) begin
      state_d     = DELAY;
      cnt_d       = '0;
      score_p1_d  = '0;
      score_p2_d  = '0;
      serve_req_d = 1'b0;
      in_play_d   = 1'b0;
      game_over_d = 1'b0;
      winner_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        DELAY: begin
          if (cnt_q == CNT_LAST) begin
            state_d     = SERVE;
            cnt_d       = '0;
            serve_req_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        SERVE: begin
          if (serve_ack) begin
            state_d     = PLAY;
            serve_req_d = 1'b0;
            in_play_d   = 1'b1;
          end else begin
            serve_req_d = 1'b1;
          end
        end

        PLAY: begin
          if (p1_evt && p2_evt) begin
            // Disputed rally: replay it without touching the scores.
            state_d   = DELAY;
            cnt_d     = '0;
            in_play_d = 1'b0;
          end else if (p1_evt) begin
            score_p1_d = p1_inc;
            in_play_d  = 1'b0;
            if (p1_inc == WIN_VAL) begin
              state_d     = OVER;
              game_over_d = 1'b1;
              winner_d    = 1'b0;
            end else begin
              state_d = DELAY;
              cnt_d   = '0;
            end
          end else if (p2_evt) begin
            score_p2_d = p2_inc;
            in_play_d  = 1'b0;
            if (p2_inc == WIN_VAL) begin
              state_d     = OVER;
              game_over_d = 1'b1;
              winner_d    = 1'b1;
            end else begin
              state_d = DELAY;
              cnt_d   = '0;
            end
          end else begin
            state_d = PLAY;
          end
        end

        OVER: begin
          state_d = OVER;
        end

        default: begin
          state_d     = IDLE;
          cnt_d       = '0;
          score_p1_d  = '0;
          score_p2_d  = '0;
          serve_req_d = 1'b0;
          in_play_d   = 1'b0;
          game_over_d = 1'b0;
          winner_d    = 1'b0;
        end
      endcase
    end
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      score_p1_q  <= '0;
      score_p2_q  <= '0;
      serve_req_q <= 1'b0;
      in_play_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      serve_req_q <= serve_req_d;
      in_play_q   <= in_play_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign score_p1  = score_p1_q;
  assign score_p2  = score_p2_q;
  assign serve_req = serve_req_q;
  assign in_play   = in_play_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper (WIN_SCORE=3, SERVE_DELAY=4).
module tb_score_keeper;

  localparam int WIN = 3;
  localparam int SD  = 4;
  localparam int CW  = 4;
`ifdef POINT_EDGE_DETECT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       new_game;
  logic       point_p1;
  logic       point_p2;
  logic       serve_ack;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       serve_req;
  logic       in_play;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  score_keeper #(
    .WIN_SCORE   (WIN),
    .SERVE_DELAY (SD),
    .CNT_W       (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .new_game  (new_game),
    .point_p1  (point_p1),
    .point_p2  (point_p2),
    .serve_ack (serve_ack),
    .score_p1  (score_p1),
    .score_p2  (score_p2),
    .serve_req (serve_req),
    .in_play   (in_play),
    .game_over (game_over),
    .winner    (winner)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_scores(input string tag, input int s1, input int s2);
    check({tag, "_p1"}, 8'(score_p1), 8'(s1));
    check({tag, "_p2"}, 8'(score_p2), 8'(s2));
  endtask

  task automatic pulse_new();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    for (int i = 0; i < LAT; i++) tick();
  endtask

  task automatic point(input logic a, input logic b);
    point_p1 = a;
    point_p2 = b;
    tick();
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    for (int i = 0; i < LAT; i++) tick();
  endtask

  task automatic do_serve();
    int n;
    n = 0;
    while (serve_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("serve_req_wait", 8'(serve_req), 8'd1);
    serve_ack = 1'b1;
    tick();
    serve_ack = 1'b0;
    check("in_play_after_ack", 8'(in_play), 8'd1);
    check("serve_req_after_ack", 8'(serve_req), 8'd0);
  endtask

  initial begin
    logic saw_req;
    reset     = 1'b1;
    new_game  = 1'b0;
    point_p1  = 1'b0;
    point_p2  = 1'b0;
    serve_ack = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    check_scores("rst", 0, 0);
    check("rst_serve_req", 8'(serve_req), 8'd0);
    check("rst_in_play", 8'(in_play), 8'd0);
    check("rst_game_over", 8'(game_over), 8'd0);
    check("rst_winner", 8'(winner), 8'd0);
    saw_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (serve_req === 1'b1) saw_req = 1'b1;
    end
    check("idle_no_serve_req", 8'(saw_req), 8'd0);
    check_scores("idle", 0, 0);

    // Serve timing: serve_req rises exactly SD cycles after DELAY entry.
    pulse_new();
    check("delay_entry_req", 8'(serve_req), 8'd0);
    for (int i = 0; i < SD - 1; i++) tick();
    check("delay_req_early", 8'(serve_req), 8'd0);
    tick();
    check("delay_req_rise", 8'(serve_req), 8'd1);
    for (int i = 0; i < 5; i++) tick();
    check("serve_req_held", 8'(serve_req), 8'd1);
    check("serve_in_play_low", 8'(in_play), 8'd0);
    serve_ack = 1'b1;
    tick();
    serve_ack = 1'b0;
    check("ack_in_play", 8'(in_play), 8'd1);
    check("ack_serve_req", 8'(serve_req), 8'd0);

    // Full match to 3: p1, p2, p1, p1.
    point(1'b1, 1'b0);
    check_scores("m1", 1, 0);
    check("m1_in_play", 8'(in_play), 8'd0);
    do_serve();
    point(1'b0, 1'b1);
    check_scores("m2", 1, 1);
    do_serve();
    point(1'b1, 1'b0);
    check_scores("m3", 2, 1);
    do_serve();
    point(1'b1, 1'b0);
    check_scores("m4", 3, 1);
    check("m4_game_over", 8'(game_over), 8'd1);
    check("m4_winner", 8'(winner), 8'd0);
    check("m4_in_play", 8'(in_play), 8'd0);
    point(1'b0, 1'b1);
    check_scores("over_frozen", 3, 1);
    check("over_game_over", 8'(game_over), 8'd1);
    serve_ack = 1'b1;
    tick();
    serve_ack = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("over_no_serve", 8'(serve_req), 8'd0);
    check("over_no_play", 8'(in_play), 8'd0);

    // New game from OVER, then reach 2/1 for the restart test.
    pulse_new();
    check_scores("ng", 0, 0);
    check("ng_game_over", 8'(game_over), 8'd0);
    check("ng_winner", 8'(winner), 8'd0);
    do_serve();
    point(1'b0, 1'b1);
    check_scores("r1", 0, 1);
    do_serve();
    point(1'b1, 1'b0);
    check_scores("r2", 1, 1);
    do_serve();
    point(1'b1, 1'b0);
    check_scores("r3", 2, 1);
    do_serve();

    // new_game and point_p1 together: restart wins, no increment.
    new_game = 1'b1;
    point_p1 = 1'b1;
    tick();
    new_game = 1'b0;
    point_p1 = 1'b0;
    for (int i = 0; i < LAT; i++) tick();
    check_scores("restart", 0, 0);
    check("restart_in_play", 8'(in_play), 8'd0);
    check("restart_serve_req", 8'(serve_req), 8'd0);

    // Build 2/2, then simultaneous points.
    do_serve();
    point(1'b1, 1'b0);
    do_serve();
    point(1'b1, 1'b0);
    do_serve();
    point(1'b0, 1'b1);
    do_serve();
    point(1'b0, 1'b1);
    check_scores("s22", 2, 2);
    do_serve();
    point(1'b1, 1'b1);
    check_scores("both", 2, 2);
    check("both_in_play", 8'(in_play), 8'd0);
    check("both_game_over", 8'(game_over), 8'd0);
    for (int i = 0; i < SD - 1; i++) tick();
    check("both_req_early", 8'(serve_req), 8'd0);
    tick();
    check("both_req_rise", 8'(serve_req), 8'd1);
    serve_ack = 1'b1;
    tick();
    serve_ack = 1'b0;
    point(1'b0, 1'b1);
    check_scores("p2win", 2, 3);
    check("p2win_game_over", 8'(game_over), 8'd1);
    check("p2win_winner", 8'(winner), 8'd1);

    // Asynchronous reset during SERVE drops serve_req without a clock edge.
    pulse_new();
    for (int i = 0; i < SD; i++) tick();
    check("pre_reset_req", 8'(serve_req), 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_req", 8'(serve_req), 8'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("post_reset_req", 8'(serve_req), 8'd0);
    check("post_reset_play", 8'(in_play), 8'd0);
    check_scores("post_reset", 0, 0);

    // point_p1 held high in PLAY scores exactly once.
    pulse_new();
    do_serve();
    point_p1 = 1'b1;
    tick();
    check("held_first_edge", 8'(score_p1), 8'(1 - LAT));
    tick();
    check("held_second_edge", 8'(score_p1), 8'd1);
    for (int i = 0; i < 18; i++) tick();
    point_p1 = 1'b0;
    tick();
    check_scores("held_final", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
